// File: rtl/arp_request.sv
// ---------------------------------------------------------------------------
// arp_request
//
// ARP initiator. On a start pulse it latches the target IPv4 address and
// requests the shared tx arbiter. Once granted, it emits a 30-byte broadcast
// ARP request (ethertype first). It then watches the rx ARP payload stream
// for a reply from the target that is addressed to us. The sender MAC of
// that reply is captured into resolved_mac.
//
// Optional feature macro:
//   ARP_REQUEST_RETRY_EN - when defined, a reply timeout retransmits the
//                          request up to MAX_RETRIES times before failing.
//                          When undefined, a timeout fails immediately.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   start, target_ip        begin resolving target_ip (sampled on start)
//   local_mac, local_ip     our own addresses
//   rx_enable, rx_data      received ARP payload stream (byte 0 = HTYPE MSB)
//   tx_enable               one-cycle grant from the tx arbiter
//   tx_request              waiting for a grant
//   tx_active, tx_data      outgoing byte stream
//   destination_mac         always broadcast
//   busy, done, fail        status / completion pulses
//   resolved, resolved_mac  sticky result and captured MAC
// ---------------------------------------------------------------------------
module arp_request #(
    parameter int TIMEOUT_CYCLES = 12_500_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] target_ip,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        rx_enable,
    input  logic [7:0]  rx_data,
    input  logic        tx_enable,
    output logic        tx_request,
    output logic        tx_active,
    output logic [7:0]  tx_data,
    output logic [47:0] destination_mac,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        resolved,
    output logic [47:0] resolved_mac
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] TX_LAST  = 5'd29;
    localparam logic [4:0] RX_LAST  = 5'd27;
    localparam logic [4:0] CNT_MAX  = 5'd31;

`ifdef ARP_REQUEST_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TXREQ = 3'd1,
        ST_TX    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    // Byte k of the 240-bit request, MSB first.
    function automatic logic [7:0] frame_byte(input logic [239:0] frame,
                                              input logic [4:0]   idx);
        logic [7:0] lsb;
        lsb = 8'd232 - {idx, 3'b000};
        frame_byte = frame[lsb +: 8];
    endfunction

    // Byte sel (0 = MSB) of an IPv4 address.
    function automatic logic [7:0] ip_byte(input logic [31:0] ip,
                                           input logic [1:0]  sel);
        case (sel)
            2'd0:    ip_byte = ip[31:24];
            2'd1:    ip_byte = ip[23:16];
            2'd2:    ip_byte = ip[15:8];
            default: ip_byte = ip[7:0];
        endcase
    endfunction

    // Does rx byte idx agree with the reply we are looking for?
    // Bytes that are not checked always agree.
    function automatic logic rx_byte_ok(input logic [4:0]  idx,
                                        input logic [7:0]  data,
                                        input logic [31:0] exp_sender_ip,
                                        input logic [31:0] exp_target_ip);
        logic [4:0] off;
        off = idx - 5'd14;
        case (idx)
            5'd6:                         rx_byte_ok = (data == 8'h00);
            5'd7:                         rx_byte_ok = (data == 8'h02);
            5'd14, 5'd15, 5'd16, 5'd17:   rx_byte_ok = (data == ip_byte(exp_sender_ip, off[1:0]));
            5'd24, 5'd25, 5'd26, 5'd27:   rx_byte_ok = (data == ip_byte(exp_target_ip, idx[1:0]));
            default:                      rx_byte_ok = 1'b1;
        endcase
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [31:0]          req_ip_r;
    logic [4:0]           tx_cnt_r;
    logic [TIMER_W-1:0]   timer_r;
    logic                 rx_enable_d_r;
    logic                 in_frame_r;
    logic [4:0]           rx_cnt_r;
    logic [47:0]          hold_mac_r;
    logic                 done_r;
    logic                 resolved_r;
    logic [47:0]          resolved_mac_r;
    logic [239:0]         tx_frame_s;
    logic [4:0]           tx_idx_s;
    logic                 match_s;
    logic                 rx_rise_s;
`ifdef ARP_REQUEST_RETRY_EN
    logic [RETRY_W-1:0]   retry_cnt_r;
`endif

    assign tx_frame_s = {16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                         local_mac, local_ip, 48'h0, req_ip_r};

    // A frame only counts if it starts while we are already waiting, so an
    // rx_enable that was high before WAIT produces no rising edge here.
    assign rx_rise_s = rx_enable & ~rx_enable_d_r;

    // Last byte of a fully matching reply; takes priority over timer expiry.
    assign match_s = (state_r == ST_WAIT) & in_frame_r & rx_enable &
                     (rx_cnt_r == RX_LAST) &
                     rx_byte_ok(rx_cnt_r, rx_data, req_ip_r, local_ip);

    // Grant cycle emits byte 0 directly, so the index is 0 outside TX.
    assign tx_idx_s        = (state_r == ST_TX) ? tx_cnt_r : 5'd0;
    assign tx_request      = (state_r == ST_TXREQ);
    assign tx_active       = (state_r == ST_TX) | ((state_r == ST_TXREQ) & tx_enable);
    assign tx_data         = tx_active ? frame_byte(tx_frame_s, tx_idx_s) : 8'h00;
    assign destination_mac = 48'hFFFF_FFFF_FFFF;
    assign busy            = (state_r == ST_TXREQ) | (state_r == ST_TX) | (state_r == ST_WAIT);
    assign fail            = (state_r == ST_FAIL);
    assign done            = done_r;
    assign resolved        = resolved_r;
    assign resolved_mac    = resolved_mac_r;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_TXREQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TXREQ: begin
                if (tx_enable) begin
                    state_nxt_s = ST_TX;
                end else begin
                    state_nxt_s = ST_TXREQ;
                end
            end
            ST_TX: begin
                if (tx_cnt_r == TX_LAST) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_TX;
                end
            end
            ST_WAIT: begin
                if (match_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_r == '0) begin
`ifdef ARP_REQUEST_RETRY_EN
                    if (retry_cnt_r < RETRY_MAX) begin
                        state_nxt_s = ST_TXREQ;
                    end else begin
                        state_nxt_s = ST_FAIL;
                    end
`else
                    state_nxt_s = ST_FAIL;
`endif
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_FAIL: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request bookkeeping: target latch, tx byte counter, timer, result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ip_r       <= 32'h0;
            tx_cnt_r       <= 5'd0;
            timer_r        <= '0;
            done_r         <= 1'b0;
            resolved_r     <= 1'b0;
            resolved_mac_r <= 48'h0;
`ifdef ARP_REQUEST_RETRY_EN
            retry_cnt_r    <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        req_ip_r   <= target_ip;
                        resolved_r <= 1'b0;
`ifdef ARP_REQUEST_RETRY_EN
                        retry_cnt_r <= '0;
`endif
                    end
                end
                ST_TXREQ: begin
                    if (tx_enable) begin
                        tx_cnt_r <= 5'd1;
                    end
                end
                ST_TX: begin
                    tx_cnt_r <= tx_cnt_r + 5'd1;
                    if (tx_cnt_r == TX_LAST) begin
                        timer_r <= TIMER_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (match_s) begin
                        resolved_mac_r <= hold_mac_r;
                        resolved_r     <= 1'b1;
                        done_r         <= 1'b1;
                    end else if (timer_r == '0) begin
`ifdef ARP_REQUEST_RETRY_EN
                        if (retry_cnt_r < RETRY_MAX) begin
                            retry_cnt_r <= retry_cnt_r + 1'b1;
                        end
`endif
                    end else begin
                        timer_r <= timer_r - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Rx reply parser: byte counter, discard flag, sender-MAC holding register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_enable_d_r <= 1'b0;
            in_frame_r    <= 1'b0;
            rx_cnt_r      <= 5'd0;
            hold_mac_r    <= 48'h0;
        end else begin
            rx_enable_d_r <= rx_enable;
            if (state_r != ST_WAIT) begin
                in_frame_r <= 1'b0;
            end else if (rx_rise_s) begin
                // Byte 0 (hardware type MSB) is not checked.
                in_frame_r <= 1'b1;
                rx_cnt_r   <= 5'd1;
            end else if (rx_enable && in_frame_r) begin
                if (rx_cnt_r != CNT_MAX) begin
                    rx_cnt_r <= rx_cnt_r + 5'd1;
                end
                if (!rx_byte_ok(rx_cnt_r, rx_data, req_ip_r, local_ip)) begin
                    in_frame_r <= 1'b0;
                end
                if ((rx_cnt_r >= 5'd8) && (rx_cnt_r <= 5'd13)) begin
                    hold_mac_r <= {hold_mac_r[39:0], rx_data};
                end
            end else begin
                in_frame_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arp_request.sv
// ---------------------------------------------------------------------------
// tb_arp_request
//
// Directed bench for arp_request with TIMEOUT_CYCLES=100, MAX_RETRIES=2.
// Expected tx bytes and rx reply frames come from hand-written tables.
// Multi-cycle corners (timeout, match on the expiry cycle, and reset in the
// middle of TX) are hand-written sequences. Honours ARP_REQUEST_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_arp_request;

    localparam int TO = 100;
    localparam int MR = 2;
`ifdef ARP_REQUEST_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] target_ip;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        rx_enable;
    logic [7:0]  rx_data;
    logic        tx_enable;
    logic        tx_request;
    logic        tx_active;
    logic [7:0]  tx_data;
    logic [47:0] destination_mac;
    logic        busy;
    logic        done;
    logic        fail;
    logic        resolved;
    logic [47:0] resolved_mac;

    arp_request #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .target_ip       (target_ip),
        .local_mac       (local_mac),
        .local_ip        (local_ip),
        .rx_enable       (rx_enable),
        .rx_data         (rx_data),
        .tx_enable       (tx_enable),
        .tx_request      (tx_request),
        .tx_active       (tx_active),
        .tx_data         (tx_data),
        .destination_mac (destination_mac),
        .busy            (busy),
        .done            (done),
        .fail            (fail),
        .resolved        (resolved),
        .resolved_mac    (resolved_mac)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       grant;
        logic [7:0] data;
    } tx_vec_t;

    typedef struct {
        logic [7:0]  op;
        logic [47:0] mac;
        logic [31:0] sip;
        logic [31:0] tip;
        logic        exp_done;
    } rx_vec_t;

    tx_vec_t tx_tab [30];
    rx_vec_t rx_tab [6];
    logic [7:0] tx_exp [30];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Start a request for C0A8_0101; returns in the grant cycle (start + 3).
    task automatic do_start;
        target_ip = 32'hC0A8_0101;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("txreq_after_start", tx_request, 1);
        chk("txactive_before_grant", tx_active, 0);
        chk("resolved_cleared", resolved, 0);
        tick();
        tick();
    endtask

    // Called in the grant cycle; checks the tx bytes from the table.
    // Returns in the cycle at index abort_at, or at WAIT entry (G+30).
    task automatic do_tx(input int abort_at);
        for (int k = 0; k < 30; k++) begin
            tx_enable = tx_tab[k].grant;
            #1;
            chk($sformatf("tx_byte%0d", k), tx_data, tx_tab[k].data);
            chk($sformatf("tx_active%0d", k), tx_active, 1);
            if (k == abort_at) begin
                tx_enable = 1'b0;
                return;
            end
            tick();
        end
        tx_enable = 1'b0;
        #1;
        chk("tx_active_end", tx_active, 0);
        chk("tx_data_idle", tx_data, 0);
        chk("tx_request_end", tx_request, 0);
        chk("busy_in_wait", busy, 1);
    endtask

    // Drive one 28-byte reply frame from the table plus one idle cycle.
    task automatic send_frame(input int i);
        logic [223:0] vec;
        vec = {16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, rx_tab[i].op,
               rx_tab[i].mac, rx_tab[i].sip, 48'h0, rx_tab[i].tip};
        for (int b = 0; b < 28; b++) begin
            rx_enable = 1'b1;
            rx_data   = vec[223 - 8*b -: 8];
            tick();
        end
        rx_enable = 1'b0;
        rx_data   = 8'h00;
        #1;
        chk($sformatf("frame%0d_done", i), done, rx_tab[i].exp_done);
        chk($sformatf("frame%0d_busy", i), busy, !rx_tab[i].exp_done);
        if (rx_tab[i].exp_done) begin
            chk($sformatf("frame%0d_resolved", i), resolved, 1);
            chk($sformatf("frame%0d_mac", i), resolved_mac, rx_tab[i].mac);
        end
        tick();
        chk($sformatf("frame%0d_done_pulse", i), done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tx_exp = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                   8'h00, 8'h01, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                   8'hC0, 8'hA8, 8'h01, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
        for (int k = 0; k < 30; k++) begin
            tx_tab[k] = '{grant: (k == 0), data: tx_exp[k]};
        end
        rx_tab[0] = '{op: 8'h02, mac: 48'h0011_2233_4455, sip: 32'hC0A8_0101, tip: 32'hC0A8_0164, exp_done: 1'b1};
        rx_tab[1] = '{op: 8'h01, mac: 48'h0011_2233_4455, sip: 32'hC0A8_0101, tip: 32'hC0A8_0164, exp_done: 1'b0};
        rx_tab[2] = '{op: 8'h02, mac: 48'h0011_2233_4455, sip: 32'hC0A8_0102, tip: 32'hC0A8_0164, exp_done: 1'b0};
        rx_tab[3] = '{op: 8'h02, mac: 48'h6677_8899_AABB, sip: 32'hC0A8_0101, tip: 32'hC0A8_0164, exp_done: 1'b1};
        rx_tab[4] = '{op: 8'h02, mac: 48'h0011_2233_4455, sip: 32'hC0A8_0101, tip: 32'hC0A8_0165, exp_done: 1'b0};
        rx_tab[5] = '{op: 8'h02, mac: 48'h0A0B_0C0D_0E0F, sip: 32'hC0A8_0101, tip: 32'hC0A8_0164, exp_done: 1'b1};

        reset_n   = 1'b0;
        start     = 1'b0;
        target_ip = 32'h0;
        local_mac = 48'h020A_0B0C_0D0E;
        local_ip  = 32'hC0A8_0164;
        rx_enable = 1'b0;
        rx_data   = 8'h00;
        tx_enable = 1'b0;
        tick();
        tick();

        // Reset values.
        chk("rst_tx_request", tx_request, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_resolved", resolved, 0);
        chk("rst_resolved_mac", resolved_mac, 0);
        chk("dest_mac", destination_mac, 48'hFFFF_FFFF_FFFF);
        reset_n = 1'b1;
        tick();

        // Basic request and matching reply.
        do_start();
        do_tx(30);
        send_frame(0);

        // Mismatched op and sender IP, then a correct frame.
        do_start();
        do_tx(30);
        send_frame(1);
        send_frame(2);
        send_frame(3);

        // Start in WAIT is ignored; mismatched target IP, then correct frame.
        do_start();
        do_tx(30);
        target_ip = 32'hC0A8_0199;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        target_ip = 32'hC0A8_0101;
        chk("start_ignored_txreq", tx_request, 0);
        chk("start_ignored_busy", busy, 1);
        send_frame(4);
        send_frame(5);

        // Timeout with no reply.
        do_start();
        do_tx(30);
        for (int a = 0; a < ATTEMPTS; a++) begin
            n = 0;
            while (!(fail || tx_request) && n < 300) begin
                tick();
                n++;
            end
            chk($sformatf("timeout%0d_cycles", a), n, TO);
            if (a < ATTEMPTS - 1) begin
                chk($sformatf("retry%0d_txreq", a), tx_request, 1);
                chk($sformatf("retry%0d_fail", a), fail, 0);
                do_tx(30);
            end else begin
                chk("timeout_fail", fail, 1);
                chk("timeout_txreq", tx_request, 0);
                chk("timeout_busy", busy, 0);
                tick();
                chk("fail_pulse", fail, 0);
                chk("fail_resolved", resolved, 0);
            end
        end

        // Reply byte 27 lands on the timer-expiry cycle (WAIT + 99).
        do_start();
        do_tx(30);
        for (int i = 0; i < 72; i++) begin
            tick();
        end
        send_frame(0);
        for (int i = 0; i < 3; i++) begin
            chk("expiry_match_fail", fail, 0);
            chk("expiry_match_txreq", tx_request, 0);
            tick();
        end
        chk("expiry_match_resolved", resolved, 1);

        // Reset at TX byte 12, then a fresh full request.
        do_start();
        do_tx(12);
        reset_n = 1'b0;
        #1;
        chk("midrst_tx_active", tx_active, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_tx_request", tx_request, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_fail", fail, 0);
        chk("midrst_resolved", resolved, 0);
        chk("midrst_resolved_mac", resolved_mac, 0);
        tick();
        reset_n = 1'b1;
        tick();
        do_start();
        do_tx(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
